// File: rtl/exc_handler_ctrl_pkg.sv
// Shared constants for the exception sequencer and the memory-address source mux:
// selector codes, cause encodings, FSM state codes and handler vector bytes.
package exc_handler_ctrl_pkg;

    typedef logic [1:0] cause_t;
    typedef logic [3:0] sel_t;

    localparam sel_t SEL_PC    = 4'b0000;
    localparam sel_t SEL_ALU   = 4'b0010;
    localparam sel_t SEL_RT    = 4'b0011;
    localparam sel_t SEL_RS    = 4'b0100;
    localparam sel_t SEL_NOTOP = 4'b0110;
    localparam sel_t SEL_OVF   = 4'b0111;
    localparam sel_t SEL_DIV0  = 4'b1000;

    localparam cause_t CAUSE_NONE  = 2'b00;
    localparam cause_t CAUSE_NOTOP = 2'b01;
    localparam cause_t CAUSE_OVF   = 2'b10;
    localparam cause_t CAUSE_DIV0  = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SAVE = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_LOAD = 3'd4;

    // Byte addresses holding the handler entry points; the address mux emits these.
    localparam logic [7:0] VEC_NOTOP = 8'd253;
    localparam logic [7:0] VEC_OVF   = 8'd254;
    localparam logic [7:0] VEC_DIV0  = 8'd255;

    function automatic sel_t cause_to_sel(input cause_t c);
        sel_t s;
        case (c)
            CAUSE_NOTOP: s = SEL_NOTOP;
            CAUSE_OVF:   s = SEL_OVF;
            CAUSE_DIV0:  s = SEL_DIV0;
            default:     s = SEL_PC;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/exc_handler_ctrl_if.sv
// Bundle between the exception sequencer (master) and its surrounding datapath (slave).
interface exc_handler_ctrl_if;
    import exc_handler_ctrl_pkg::*;

    logic        exc_not_op;
    logic        exc_overflow;
    logic        exc_div0;
    logic [31:0] pc_in;
    logic [31:0] mem_rdata;
    logic        sel_valid;
    sel_t        sel_code;
    logic        mem_rd;
    logic [31:0] epc;
    logic        epc_wr;
    logic [31:0] pc_next;
    logic        pc_load;
    logic        busy;
    cause_t      cause;

    modport master (
        input  exc_not_op, exc_overflow, exc_div0, pc_in, mem_rdata,
        output sel_valid, sel_code, mem_rd, epc, epc_wr, pc_next, pc_load, busy, cause
    );

    modport slave (
        output exc_not_op, exc_overflow, exc_div0, pc_in, mem_rdata,
        input  sel_valid, sel_code, mem_rd, epc, epc_wr, pc_next, pc_load, busy, cause
    );

endinterface

// File: rtl/exc_handler_ctrl_prio.sv
// Combinational 3-to-2 priority encoder: NOT_op beats overflow beats divide-by-zero.
module exc_priority_enc
    import exc_handler_ctrl_pkg::*;
(
    input  logic   exc_not_op_i,
    input  logic   exc_overflow_i,
    input  logic   exc_div0_i,
    output cause_t cause_o
);

    // Select the highest-priority pending exception.
    always_comb begin
        cause_o = CAUSE_NONE;
        if (exc_not_op_i) begin
            cause_o = CAUSE_NOTOP;
        end else if (exc_overflow_i) begin
            cause_o = CAUSE_OVF;
        end else if (exc_div0_i) begin
            cause_o = CAUSE_DIV0;
        end else begin
            cause_o = CAUSE_NONE;
        end
    end

endmodule

// File: rtl/exc_handler_ctrl.sv
// Exception sequencer: saves EPC, steers the address mux to the handler vector,
// waits out memory latency, then loads PC with the vector byte.
module exc_handler_ctrl
    import exc_handler_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 32'd1,
    parameter int unsigned EPC_OFFSET = 32'd4
) (
    input  logic               clk,
    input  logic               reset_n,
    exc_handler_ctrl_if.master bus
);

    localparam logic [3:0]  LAT_M1_C  = 4'(MEM_LAT - 32'd1);
    localparam logic [31:0] EPC_OFF_C = 32'(EPC_OFFSET);

    cause_t      enc_cause_s;
    logic        rdata_unused_s;
    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    cause_t      cause_lat_q, cause_lat_d;
    cause_t      cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    sel_t        sel_code_q, sel_code_d;
    logic [31:0] pc_next_q, pc_next_d;

    exc_priority_enc u_prio (
        .exc_not_op_i   (bus.exc_not_op),
        .exc_overflow_i (bus.exc_overflow),
        .exc_div0_i     (bus.exc_div0),
        .cause_o        (enc_cause_s)
    );

    assign rdata_unused_s = ^bus.mem_rdata[31:8];

    // Next-state and datapath register updates for the service sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cause_lat_d = cause_lat_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        sel_code_d  = sel_code_q;
        pc_next_d   = pc_next_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_cause_s != CAUSE_NONE) begin
                    cause_lat_d = enc_cause_s;
                    state_d     = ST_SAVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE: begin
                epc_d      = bus.pc_in - EPC_OFF_C;
                cause_d    = cause_lat_q;
                sel_code_d = cause_to_sel(cause_lat_q);
                state_d    = ST_ADDR;
            end
            ST_ADDR: begin
                cnt_d   = LAT_M1_C;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Data is valid in the last WAIT cycle, so pc_next is ready alongside pc_load.
                if (cnt_q == 4'd0) begin
                    pc_next_d = {24'h000000, bus.mem_rdata[7:0]};
                    state_d   = ST_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            cause_lat_q <= CAUSE_NONE;
            cause_q     <= CAUSE_NONE;
            epc_q       <= 32'h0000_0000;
            sel_code_q  <= SEL_PC;
            pc_next_q   <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cause_lat_q <= cause_lat_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            sel_code_q  <= sel_code_d;
            pc_next_q   <= pc_next_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.sel_valid = (state_q == ST_ADDR) || (state_q == ST_WAIT);
    assign bus.mem_rd    = (state_q == ST_ADDR) || (state_q == ST_WAIT);
    assign bus.epc_wr    = (state_q == ST_SAVE);
    assign bus.pc_load   = (state_q == ST_LOAD);
    assign bus.sel_code  = sel_code_q;
    assign bus.epc       = epc_q;
    assign bus.cause     = cause_q;
    assign bus.pc_next   = pc_next_q;

endmodule

// File: tb/tb_exc_handler_ctrl.sv
// Directed bench for exc_handler_ctrl: one DUT with MEM_LAT=1 and one with MEM_LAT=3
// share the same stimulus; each scenario observes the DUT selected by sel3.
module tb_exc_handler_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        exc_not_op = 1'b0, exc_overflow = 1'b0, exc_div0 = 1'b0;
    logic [31:0] pc_in = 32'h0, mem_rdata = 32'h0;
    bit          sel3 = 1'b0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    exc_handler_ctrl_if if1 ();
    exc_handler_ctrl_if if3 ();

    assign if1.exc_not_op = exc_not_op;   assign if3.exc_not_op = exc_not_op;
    assign if1.exc_overflow = exc_overflow; assign if3.exc_overflow = exc_overflow;
    assign if1.exc_div0 = exc_div0;       assign if3.exc_div0 = exc_div0;
    assign if1.pc_in = pc_in;             assign if3.pc_in = pc_in;
    assign if1.mem_rdata = mem_rdata;     assign if3.mem_rdata = mem_rdata;

    exc_handler_ctrl #(.MEM_LAT(1), .EPC_OFFSET(4)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.master));
    exc_handler_ctrl #(.MEM_LAT(3), .EPC_OFFSET(4)) dut3 (.clk(clk), .reset_n(reset_n), .bus(if3.master));

    logic        o_busy, o_selv, o_rd, o_epcwr, o_load;
    logic [3:0]  o_sc;
    logic [1:0]  o_cause;
    logic [31:0] o_epc, o_pcn;
    assign o_busy  = sel3 ? if3.busy      : if1.busy;
    assign o_selv  = sel3 ? if3.sel_valid : if1.sel_valid;
    assign o_rd    = sel3 ? if3.mem_rd    : if1.mem_rd;
    assign o_epcwr = sel3 ? if3.epc_wr    : if1.epc_wr;
    assign o_load  = sel3 ? if3.pc_load   : if1.pc_load;
    assign o_sc    = sel3 ? if3.sel_code  : if1.sel_code;
    assign o_cause = sel3 ? if3.cause     : if1.cause;
    assign o_epc   = sel3 ? if3.epc       : if1.epc;
    assign o_pcn   = sel3 ? if3.pc_next   : if1.pc_next;

    // Results of the most recent observe() call.
    int          n_busy, n_selv, n_load, load_idx, n_epcwr;
    logic [3:0]  sc;
    bit          sc_stable, rd_ok;
    logic [31:0] pcn;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        {exc_not_op, exc_overflow, exc_div0} = 3'b000;
        repeat (10) tick();
    endtask

    // Step through one service (bounded), optionally raising inj_vec during busy cycle inj_at.
    task automatic observe(input int inj_at, input logic [2:0] inj_vec);
        bit seen = 1'b0;
        n_busy = 0; n_selv = 0; n_load = 0; load_idx = -1; n_epcwr = 0;
        sc = 4'hx; sc_stable = 1'b1; rd_ok = 1'b1; pcn = 32'hx;
        for (int c = 0; c < 40; c++) begin
            tick();
            {exc_not_op, exc_overflow, exc_div0} = 3'b000;
            if (o_busy) begin
                n_busy++; seen = 1'b1;
                if (n_busy == inj_at) {exc_not_op, exc_overflow, exc_div0} = inj_vec;
            end
            if (o_selv) begin
                if (n_selv == 0) sc = o_sc; else if (o_sc !== sc) sc_stable = 1'b0;
                n_selv++;
            end
            if (o_rd !== o_selv) rd_ok = 1'b0;
            if (o_epcwr) n_epcwr++;
            if (o_load) begin n_load++; load_idx = n_busy; pcn = o_pcn; end
            if (seen && !o_busy) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1; #1 reset_n = 1'b0;
        tick(); tick();
        sel3 = 1'b0;
        checks++; if ({o_busy, o_selv, o_rd, o_epcwr, o_load} !== 5'b0) begin failures++; $display("FAIL rst1_strobes got=%b exp=00000", {o_busy, o_selv, o_rd, o_epcwr, o_load}); end
        checks++; if ({o_epc, o_pcn, o_sc, o_cause} !== 70'h0) begin failures++; $display("FAIL rst1_regs got=%h exp=0", {o_epc, o_pcn, o_sc, o_cause}); end
        sel3 = 1'b1; #1;
        checks++; if ({o_busy, o_selv, o_rd, o_epcwr, o_load} !== 5'b0) begin failures++; $display("FAIL rst3_strobes got=%b exp=00000", {o_busy, o_selv, o_rd, o_epcwr, o_load}); end
        checks++; if ({o_epc, o_pcn, o_sc, o_cause} !== 70'h0) begin failures++; $display("FAIL rst3_regs got=%h exp=0", {o_epc, o_pcn, o_sc, o_cause}); end
        reset_n = 1'b1;
        settle();
    endtask

    task automatic test_overflow();
        sel3 = 1'b0; settle();
        pc_in = 32'h0000_0010; mem_rdata = 32'h0000_00AB; exc_overflow = 1'b1;
        observe(-1, 3'b000);
        checks++; if (n_busy != 4) begin failures++; $display("FAIL ovf_busy_cycles got=%0d exp=4", n_busy); end
        checks++; if (n_selv != 2) begin failures++; $display("FAIL ovf_selv_cycles got=%0d exp=2", n_selv); end
        checks++; if (sc !== 4'b0111 || !sc_stable) begin failures++; $display("FAIL ovf_sel_code got=%b stable=%0d exp=0111", sc, sc_stable); end
        checks++; if (n_epcwr != 1) begin failures++; $display("FAIL ovf_epc_wr got=%0d exp=1", n_epcwr); end
        checks++; if (n_load != 1 || load_idx != 4) begin failures++; $display("FAIL ovf_pc_load got=%0d@%0d exp=1@4", n_load, load_idx); end
        checks++; if (pcn !== 32'h0000_00AB) begin failures++; $display("FAIL ovf_pc_next got=%h exp=000000ab", pcn); end
        checks++; if (o_epc !== 32'h0000_000C) begin failures++; $display("FAIL ovf_epc got=%h exp=0000000c", o_epc); end
        checks++; if (o_cause !== 2'b10) begin failures++; $display("FAIL ovf_cause got=%b exp=10", o_cause); end
        checks++; if (!rd_ok) begin failures++; $display("FAIL ovf_mem_rd got=diverged exp=tracks_sel_valid"); end
        checks++; if (o_sc !== 4'b0111) begin failures++; $display("FAIL ovf_sel_hold got=%b exp=0111", o_sc); end
    endtask

    task automatic test_priority();
        sel3 = 1'b0; settle();
        pc_in = 32'h0000_0100; mem_rdata = 32'h0123_45FD;
        exc_not_op = 1'b1; exc_div0 = 1'b1;
        observe(-1, 3'b000);
        checks++; if (o_cause !== 2'b01) begin failures++; $display("FAIL prio_cause got=%b exp=01", o_cause); end
        checks++; if (sc !== 4'b0110) begin failures++; $display("FAIL prio_sel_code got=%b exp=0110", sc); end
        checks++; if (pcn !== 32'h0000_00FD) begin failures++; $display("FAIL prio_pc_next got=%h exp=000000fd", pcn); end
        checks++; if (o_epc !== 32'h0000_00FC) begin failures++; $display("FAIL prio_epc got=%h exp=000000fc", o_epc); end
    endtask

    task automatic test_div0_lat3();
        sel3 = 1'b1; settle();
        pc_in = 32'h0000_2000; mem_rdata = 32'hFFFF_FFFF; exc_div0 = 1'b1;
        observe(-1, 3'b000);
        checks++; if (n_selv != 4) begin failures++; $display("FAIL div0_selv_cycles got=%0d exp=4", n_selv); end
        checks++; if (sc !== 4'b1000 || !sc_stable) begin failures++; $display("FAIL div0_sel_code got=%b stable=%0d exp=1000", sc, sc_stable); end
        checks++; if (n_busy != 6) begin failures++; $display("FAIL div0_busy_cycles got=%0d exp=6", n_busy); end
        checks++; if (n_load != 1 || load_idx != 6) begin failures++; $display("FAIL div0_pc_load got=%0d@%0d exp=1@6", n_load, load_idx); end
        checks++; if (pcn !== 32'h0000_00FF) begin failures++; $display("FAIL div0_pc_next got=%h exp=000000ff", pcn); end
        checks++; if (o_cause !== 2'b11) begin failures++; $display("FAIL div0_cause got=%b exp=11", o_cause); end
        checks++; if (o_epc !== 32'h0000_1FFC) begin failures++; $display("FAIL div0_epc got=%h exp=00001ffc", o_epc); end
    endtask

    task automatic test_ignore_busy();
        int late_busy = 0;
        sel3 = 1'b1; settle();
        pc_in = 32'h0000_0500; mem_rdata = 32'h0000_0011; exc_not_op = 1'b1;
        observe(4, 3'b010);
        checks++; if (n_load != 1) begin failures++; $display("FAIL ign_pc_load_count got=%0d exp=1", n_load); end
        checks++; if (o_cause !== 2'b01) begin failures++; $display("FAIL ign_cause got=%b exp=01", o_cause); end
        checks++; if (n_busy != 6) begin failures++; $display("FAIL ign_busy_cycles got=%0d exp=6", n_busy); end
        repeat (6) begin tick(); if (o_busy) late_busy++; end
        checks++; if (late_busy != 0) begin failures++; $display("FAIL ign_second_service got=%0d exp=0", late_busy); end
        checks++; if (o_epc !== 32'h0000_04FC) begin failures++; $display("FAIL ign_epc got=%h exp=000004fc", o_epc); end
    endtask

    task automatic test_wrap();
        sel3 = 1'b0; settle();
        pc_in = 32'h0000_0000; mem_rdata = 32'h0000_0042; exc_overflow = 1'b1;
        observe(-1, 3'b000);
        checks++; if (o_epc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_epc got=%h exp=fffffffc", o_epc); end
    endtask

    task automatic test_back_to_back();
        sel3 = 1'b0; settle();
        pc_in = 32'h0000_0080; mem_rdata = 32'h0000_0033; exc_overflow = 1'b1;
        observe(4, 3'b001);
        checks++; if (n_busy != 4 || o_busy !== 1'b0) begin failures++; $display("FAIL b2b_load_exc_ignored got=%0d busy=%b exp=4 busy=0", n_busy, o_busy); end
        checks++; if (o_cause !== 2'b10) begin failures++; $display("FAIL b2b_first_cause got=%b exp=10", o_cause); end
        pc_in = 32'h0000_0090; exc_not_op = 1'b1;
        observe(-1, 3'b000);
        checks++; if (n_busy != 4) begin failures++; $display("FAIL b2b_second_busy got=%0d exp=4", n_busy); end
        checks++; if (o_cause !== 2'b01) begin failures++; $display("FAIL b2b_second_cause got=%b exp=01", o_cause); end
        checks++; if (o_epc !== 32'h0000_008C) begin failures++; $display("FAIL b2b_second_epc got=%h exp=0000008c", o_epc); end
    endtask

    task automatic test_reset_mid();
        int loads = 0, busys = 0;
        sel3 = 1'b1; settle();
        pc_in = 32'h0000_0040; mem_rdata = 32'h0000_0077; exc_div0 = 1'b1;
        tick(); exc_div0 = 1'b0;
        tick(); tick();
        checks++; if (o_busy !== 1'b1 || o_epc !== 32'h0000_003C) begin failures++; $display("FAIL rmid_pre got busy=%b epc=%h exp busy=1 epc=0000003c", o_busy, o_epc); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({o_busy, o_selv, o_rd, o_epcwr, o_load} !== 5'b0) begin failures++; $display("FAIL rmid_strobes got=%b exp=00000", {o_busy, o_selv, o_rd, o_epcwr, o_load}); end
        checks++; if ({o_epc, o_pcn, o_sc, o_cause} !== 70'h0) begin failures++; $display("FAIL rmid_regs got=%h exp=0", {o_epc, o_pcn, o_sc, o_cause}); end
        reset_n = 1'b1;
        repeat (10) begin tick(); if (o_load) loads++; if (o_busy) busys++; end
        checks++; if (loads != 0 || busys != 0) begin failures++; $display("FAIL rmid_after_release got loads=%0d busy=%0d exp=0/0", loads, busys); end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_priority();
        test_div0_lat3();
        test_ignore_busy();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_handler_ctrl.md
Name: exc_handler_ctrl

Overview:
- Sequential exception sequencer upstream of the memory-address source mux; drives that mux's 4-bit selector while an exception is being serviced.
- Accepts exception pulses from decode (invalid opcode), ALU (overflow) and divider (divide by zero).
- Saves EPC, points memory at the fixed handler-vector byte (253/254/255), waits out memory latency, then loads PC with the zero-extended vector byte.
- Stalls the main control unit for the duration of service.

Parameters:
- MEM_LAT, 1: cycles from address presentation to valid mem_rdata; legal 1..15.
- EPC_OFFSET, 4: subtracted from pc_in to form EPC, because pc_in is already incremented.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- exc_not_op  in  1  invalid-opcode pulse from decode
- exc_overflow  in  1  ALU overflow pulse
- exc_div0  in  1  divider divide-by-zero pulse
- pc_in  in  32  current PC register value
- mem_rdata  in  32  memory read data
- sel_valid  out  1  when high, control unit forwards sel_code to the address mux selector
- sel_code  out  4  address-mux selector (0110 NOT_op, 0111 overflow, 1000 divBy0, 0000 otherwise)
- mem_rd  out  1  memory read strobe
- epc  out  32  exception PC register
- epc_wr  out  1  one-cycle pulse when epc updates
- pc_next  out  32  handler address to PC
- pc_load  out  1  one-cycle PC write enable
- busy  out  1  stall to main control unit
- cause  out  2  last cause: 01 NOT_op, 10 overflow, 11 divBy0, 00 none

Behaviour:
- Reset (async, reset_n low):
  - State IDLE.
  - All outputs 0: epc=0, cause=00, sel_code=0000, pc_next=0.
  - Wait counter cleared.
  - Reset mid-service aborts immediately; no partial pc_load.
- States: IDLE, SAVE, ADDR, WAIT, LOAD.
- IDLE:
  - busy=0, sel_valid=0.
  - If any exc_* is high on a rising edge, latch the cause and go to SAVE.
  - Priority when several are high together: NOT_op > overflow > divBy0.
- SAVE (1 cycle):
  - busy=1.
  - epc <= pc_in - EPC_OFFSET, with 32-bit wrap (pc_in=0 gives 0xFFFFFFFC).
  - epc_wr=1 in this cycle.
  - cause register updated. → ADDR.
- ADDR (1 cycle):
  - sel_valid=1, mem_rd=1.
  - sel_code from latched cause: 0110 / 0111 / 1000.
  - Load wait counter with MEM_LAT-1. → WAIT.
- WAIT:
  - sel_valid, sel_code and mem_rd held.
  - Counter decrements each cycle; when it reads 0, go to LOAD.
  - With MEM_LAT=1, WAIT lasts exactly 1 cycle.
- LOAD (1 cycle):
  - pc_next <= {24'b0, mem_rdata[7:0]}; pc_load=1.
  - sel_valid=0, mem_rd=0. → IDLE.
  - busy drops in the cycle after LOAD.
- Total service: 3+MEM_LAT cycles with busy high (SAVE..LOAD).
- Exceptions while busy=1 are ignored (not queued); cause and epc are unchanged until the next service.
- An exception asserted in the same cycle LOAD completes is ignored. An exception in the first IDLE cycle afterwards is accepted.
- sel_code and pc_next hold their last values while idle; consumers qualify them with sel_valid / pc_load.
- All outputs are registered or decoded from state only; no combinational path from exc_* to any output.

Decomposition:
- Shared package holds:
  - selector codes SEL_PC=0000, SEL_ALU=0010, SEL_RT=0011, SEL_RS=0100, SEL_NOTOP=0110, SEL_OVF=0111, SEL_DIV0=1000.
  - cause encodings.
  - state enumeration.
  - handler vector constants 253/254/255 (shared with the address mux).
- One natural sub-module: exc_priority_enc, a combinational 3-to-2 priority encoder that produces the cause.
- FSM and counter stay in the top module.

Test Plan:
- Overflow at pc_in=0x00000010, MEM_LAT=1, mem_rdata=0x000000AB → epc=0x0000000C with epc_wr pulse; sel_code=0111 for 2 cycles; pc_load with pc_next=0x000000AB; busy high exactly 4 cycles; cause=10.
- exc_not_op and exc_div0 asserted together → cause=01, sel_code=0110.
- MEM_LAT=3, div0 → sel_valid high 4 cycles (ADDR + 3 WAIT), sel_code=1000; pc_load on 6th busy cycle; busy high 6 cycles.
- overflow pulse during WAIT of a NOT_op service → single pc_load, cause stays 01, no second service.
- reset_n low during WAIT → all outputs 0 immediately (async); no pc_load after release.
- pc_in=0x00000000, any exception → epc=0xFFFFFFFC (wrap).
